mem_access_unit: RTL and testbench

- Memory-stage responder for the 3-stage pipeline.
- Consumes the registered memory-stage controls: read enable, write enable, address, store data and instruction.
- Runs a req/ack transaction on the data-memory bus, with byte/half/word lane steering and load sign/zero extension.
- Drives a stall back to the pipeline registers until the access completes. Provides load data to the writeback mux.

---
 rtl/mem_access_unit.sv | 114 +++++++++++
 tb/tb_mem_access_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage bus responder with lane steering, load extension and timeout; optional misalignment trap via MEM_MISALIGN_TRAP_EN
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_wr_mem_mem,
  input  logic              mem_wr_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [31:0]       wdata_mem,
  input  logic [31:0]       instruction_mem,
  output logic              stall,
  output logic [31:0]       rdata_wb,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        ld;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        access, is_load, is_byte, is_half, trap;
  logic [2:0]  f3_in;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, ext;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic        unused;
  assign unused = &{1'b0, instruction_mem[31:15], instruction_mem[11:0]};
  assign access  = rd_wr_mem_mem | mem_wr_mem;
  assign is_load = rd_wr_mem_mem & ~mem_wr_mem;
  assign f3_in   = instruction_mem[14:12];
  assign off_in  = addr_mem[1:0];
  // funct3 x00 is byte, x01 is half, everything else (incl. reserved) is word
  assign is_byte = f3_in[1:0] == 2'b00;
  assign is_half = f3_in[1:0] == 2'b01;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_half ? off_in[0] : (~is_byte & (off_in != 2'b00));
`else
  assign trap = 1'b0;
`endif
  // store lane steering and load extension from the latched access shape
  always_comb begin
    be_in    = is_byte ? 4'b0001 << off_in : is_half ? (off_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_in = is_byte ? {4{wdata_mem[7:0]}} : is_half ? {2{wdata_mem[15:0]}} : wdata_mem;
    rb       = 8'(bus_rdata >> {off, 3'b000});
    rh       = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext      = f3[1:0] == 2'b00 ? {{24{~f3[2] & rb[7]}}, rb} :
               f3[1:0] == 2'b01 ? {{16{~f3[2] & rh[15]}}, rh} : bus_rdata;
  end
  // the pipeline is held from the accepting IDLE cycle through every REQ cycle
  assign stall = ~reset & ((state == IDLE & access) | state == REQ);
  // access sequencer: IDLE accepts, REQ waits for ack or timeout, DONE releases the pipeline
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ld        <= 1'b0;
      f3        <= '0;
      off       <= '0;
      rdata_wb  <= '0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          cnt     <= '0;
          ld      <= is_load;
          f3      <= f3_in;
          off     <= off_in;
          bus_err <= trap;
          if (trap) begin
            state <= DONE;
            if (is_load) rdata_wb <= '0;
          end else begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= mem_wr_mem;
            bus_addr  <= {addr_mem[ADDR_W-1:2], 2'b00};
            bus_wdata <= wdata_in;
            bus_be    <= be_in;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (ld) rdata_wb <= ext;
          end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            if (ld) rdata_wb <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven check of mem_access_unit (TIMEOUT_CYCLES=4), plus reset-in-REQ sequence
module tb_mem_access_unit;
  logic        clock, reset, rd, wr, stall, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] addr, wdata, instr, rdata_wb, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  int checks = 0, failures = 0;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .rd_wr_mem_mem(rd), .mem_wr_mem(wr),
    .addr_mem(addr), .wdata_mem(wdata), .instruction_mem(instr),
    .stall(stall), .rdata_wb(rdata_wb), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          delay;
    logic        we;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewdata, erwb;
    logic        eerr;
    int          estall, ereq;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic r, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rdt, int d, logic we, logic [31:0] ea, logic [3:0] eb,
                              logic [31:0] ew, logic [31:0] er, logic ee, int es, int eq);
    vec_t v;
    v.rd = r; v.wr = w; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rdt; v.delay = d;
    v.we = we; v.eaddr = ea; v.ebe = eb; v.ewdata = ew; v.erwb = er; v.eerr = ee;
    v.estall = es; v.ereq = eq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int sn = 0, rn = 0;
    bit done = 0;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    r_we = 0; r_addr = 0; r_wdata = 0; r_be = 0;
    @(negedge clock);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    instr = {17'b0, v.f3, 12'b0}; bus_ack = 0; bus_rdata = v.rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) sn++;
      else done = 1;
      if (bus_req) begin
        if (rn == 0) begin r_we = bus_we; r_addr = bus_addr; r_wdata = bus_wdata; r_be = bus_be; end
        rn++;
      end
      bus_ack = bus_req && (rn > v.delay);
      if (!done) @(negedge clock);
    end
    rd = 0; wr = 0; bus_ack = 0;
    if (!done) begin
      failures++; checks++;
      $display("FAIL %s_timeout: got stall still high expected stall low within 40 cycles", tag);
    end else begin
      chk({tag, "_stall_cycles"}, sn, v.estall);
      chk({tag, "_req_cycles"}, rn, v.ereq);
      chk({tag, "_rdata_wb"}, rdata_wb, v.erwb);
      chk({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, v.eerr});
      chk({tag, "_req_low"}, {31'b0, bus_req}, 32'd0);
      if (v.ereq > 0) begin
        chk({tag, "_we"}, {31'b0, r_we}, {31'b0, v.we});
        chk({tag, "_addr"}, r_addr, v.eaddr);
        chk({tag, "_be"}, {28'b0, r_be}, {28'b0, v.ebe});
        if (v.we) chk({tag, "_wdata"}, r_wdata, v.ewdata);
      end
    end
  endtask

  initial begin
    reset = 1; rd = 0; wr = 0; addr = 0; wdata = 0; instr = 0; bus_ack = 0; bus_rdata = 0;
    //      rd wr f3      addr     wdata          rdata          dly we eaddr     ebe      ewdata         erwb           err st rq
    vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0,          32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 32'h0,         32'hDEADBEEF, 0, 2, 1);
    vecs[1]  = mk(0, 1, 3'b000, 32'h203, 32'h000000A5,   32'h0,        0, 1, 32'h200, 4'b1000, 32'hA5A5A5A5,  32'hDEADBEEF, 0, 2, 1);
    vecs[2]  = mk(1, 0, 3'b000, 32'h102, 32'h0,          32'h1280FF00, 1, 0, 32'h100, 4'b0100, 32'h0,         32'hFFFFFF80, 0, 3, 2);
    vecs[3]  = mk(1, 0, 3'b101, 32'h102, 32'h0,          32'h1280FF00, 0, 0, 32'h100, 4'b1100, 32'h0,         32'h00001280, 0, 2, 1);
    vecs[4]  = mk(1, 0, 3'b001, 32'h100, 32'h0,          32'h1280FF00, 0, 0, 32'h100, 4'b0011, 32'h0,         32'hFFFFFF00, 0, 2, 1);
    vecs[5]  = mk(1, 0, 3'b100, 32'h101, 32'h0,          32'h1280FF00, 0, 0, 32'h100, 4'b0010, 32'h0,         32'h000000FF, 0, 2, 1);
    vecs[6]  = TRAP ?
               mk(0, 1, 3'b001, 32'h203, 32'h1234BEEF,   32'h0,        0, 1, 32'h200, 4'b1100, 32'hBEEFBEEF,  32'h000000FF, 1, 1, 0) :
               mk(0, 1, 3'b001, 32'h203, 32'h1234BEEF,   32'h0,        0, 1, 32'h200, 4'b1100, 32'hBEEFBEEF,  32'h000000FF, 0, 2, 1);
    vecs[7]  = mk(0, 1, 3'b010, 32'h0,   32'hCAFEF00D,   32'h0,        0, 1, 32'h0,   4'b1111, 32'hCAFEF00D,  32'h000000FF, 0, 2, 1);
    vecs[8]  = mk(1, 0, 3'b010, 32'h104, 32'h0,          32'h12345678, 99, 0, 32'h104, 4'b1111, 32'h0,        32'h0,        1, 5, 4);
    vecs[9]  = mk(1, 1, 3'b010, 32'h108, 32'h11223344,   32'hFFFFFFFF, 0, 1, 32'h108, 4'b1111, 32'h11223344,  32'h0,        0, 2, 1);
    vecs[10] = mk(1, 0, 3'b011, 32'h10C, 32'h0,          32'h55AA55AA, 0, 0, 32'h10C, 4'b1111, 32'h0,         32'h55AA55AA, 0, 2, 1);
    vecs[11] = TRAP ?
               mk(1, 0, 3'b010, 32'h101, 32'h0,          32'h87654321, 0, 0, 32'h100, 4'b1111, 32'h0,         32'h0,        1, 1, 0) :
               mk(1, 0, 3'b010, 32'h101, 32'h0,          32'h87654321, 0, 0, 32'h100, 4'b1111, 32'h0,         32'h87654321, 0, 2, 1);
    vecs[12] = mk(0, 1, 3'b000, 32'h201, 32'h0000005A,   32'h0,        0, 1, 32'h200, 4'b0010, 32'h5A5A5A5A,
                  TRAP ? 32'h0 : 32'h87654321, 0, 2, 1);
    vecs[13] = mk(1, 0, 3'b010, 32'h110, 32'h0,          32'h0BADF00D, 3, 0, 32'h110, 4'b1111, 32'h0,         32'h0BADF00D, 0, 5, 4);
    vecs[14] = mk(1, 0, 3'b001, 32'h102, 32'h0,          32'h80001234, 0, 0, 32'h100, 4'b1100, 32'h0,         32'hFFFF8000, 0, 2, 1);
    vecs[15] = mk(0, 1, 3'b001, 32'h200, 32'h0000ABCD,   32'h0,        0, 1, 32'h200, 4'b0011, 32'hABCDABCD,  32'hFFFF8000, 0, 2, 1);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    chk("rst_rdata_wb", rdata_wb, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    @(negedge clock);
    rd = 1; addr = 32'h100; instr = {17'b0, 3'b010, 12'b0}; bus_ack = 0; bus_rdata = 32'h13572468;
    @(negedge clock);
    #1;
    chk("mid_req_up", {31'b0, bus_req}, 32'd1);
    @(negedge clock);
    reset = 1;
    #1;
    chk("mid_rst_req", {31'b0, bus_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_err", {31'b0, bus_err}, 32'd0);
    chk("mid_rst_rdata_wb", rdata_wb, 32'd0);
    @(negedge clock);
    reset = 0; rd = 0;
    run_vec(mk(0, 1, 3'b010, 32'h0, 32'h0F0F1234, 32'h0, 0, 1, 32'h0, 4'b1111, 32'h0F0F1234, 32'h0, 0, 2, 1), "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
